// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: widths, opcodes, forwarding codes, M-stage FSM encoding.
package riscv_pkg;

    localparam int WORD_BITWIDTH    = 32;
    localparam int REG_NUM_BITWIDTH = 5;
    localparam int MEM_CNT_BITWIDTH = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Tracks an outstanding data-memory request and flags a timeout after MEM_TIMEOUT waiting cycles.
// Latency: timeout is combinational in the cycle the counter reaches MEM_TIMEOUT.
// Backpressure: none of its own; the request is held by the owning stage until ack or timeout.
module mem_req_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic in_wait,
    output logic timeout
);

    mem_state_t                  state, state_nxt;
    logic [MEM_CNT_BITWIDTH-1:0] cnt, cnt_nxt;
    logic                        cnt_hit;

    assign cnt_hit = (cnt == MEM_CNT_BITWIDTH'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            MEM_IDLE: begin
                if (req && !ack) begin
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = MEM_CNT_BITWIDTH'(1);
                end
            end
            MEM_WAIT: begin
                // A late ack on the final cycle still wins over the timeout.
                if (ack || cnt_hit) begin
                    state_nxt = MEM_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + MEM_CNT_BITWIDTH'(1);
                end
            end
        endcase
    end

    always_comb begin
        in_wait = (state == MEM_WAIT);
        timeout = in_wait && !ack && cnt_hit;
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register plus data-memory access; feeds the MEM/WB register and the M-stage forward path.
// Latency: ALU op EX->WB 2 cycles; memory op 2 + N cycles where N is req-to-ack delay.
// Backpressure: stall holds IF/ID/EX while a request is outstanding; M holds its contents meanwhile.
module mem_stage
    import riscv_pkg::is_misaligned;
#(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int MEM_TIMEOUT      = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex_valid,
    input  logic [WORD_BITWIDTH-1:0]    ex_ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    ex_storeData,
    input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
    input  logic                        ex_regWrite,
    input  logic                        ex_memRead,
    input  logic                        ex_memWrite,
    input  logic                        flush,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [WORD_BITWIDTH-1:0]    dmem_addr,
    output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
    input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
    input  logic                        dmem_ack,
    output logic                        stall,
    output logic [WORD_BITWIDTH-1:0]    fd_mem_data,
    output logic [REG_NUM_BITWIDTH-1:0] mem_rd,
    output logic                        mem_regWrite,
    output logic                        wb_valid,
    output logic [REG_NUM_BITWIDTH-1:0] wb_rd,
    output logic                        wb_regWrite,
    output logic [WORD_BITWIDTH-1:0]    wb_data,
    output logic                        mem_err
);

    typedef struct packed {
        logic [WORD_BITWIDTH-1:0]    alu_result;
        logic [WORD_BITWIDTH-1:0]    store_data;
        logic [REG_NUM_BITWIDTH-1:0] rd;
        logic                        reg_write;
        logic                        mem_read;
        logic                        mem_write;
    } m_reg_t;

    m_reg_t m_q;
    m_reg_t m_d;
    logic   m_valid;
    logic   m_mem;
    logic   m_mis;
    logic   retire;
    logic   wb_valid_nxt;
    logic   in_wait;
    logic   timeout;

    assign m_d = '{
        alu_result: ex_ALUresult,
        store_data: ex_storeData,
        rd:         ex_rd,
        reg_write:  ex_regWrite,
        mem_read:   ex_memRead,
        mem_write:  ex_memWrite
    };

    always_comb begin
        m_mem        = m_valid && (m_q.mem_read || m_q.mem_write);
        m_mis        = m_mem && is_misaligned(m_q.alu_result[1:0]);
        retire       = m_valid && (!m_mem || m_mis || dmem_ack || timeout);
        stall        = m_valid && !retire;
        wb_valid_nxt = retire && !m_mis && !timeout;
    end

    // Address/data come straight from the M register, which is frozen while stalled.
    assign dmem_req     = m_mem && !m_mis;
    assign dmem_we      = m_q.mem_write;
    assign dmem_addr    = m_q.alu_result;
    assign dmem_wdata   = m_q.store_data;
    assign fd_mem_data  = m_q.alu_result;
    assign mem_rd       = m_q.rd;
    assign mem_regWrite = m_valid && m_q.reg_write;

    mem_req_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_req_fsm (
        .clk     (clk),
        .rst     (rst),
        .req     (dmem_req),
        .ack     (dmem_ack),
        .in_wait (in_wait),
        .timeout (timeout)
    );

    // flush only ever kills the EX instruction; a stalled M entry is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_q     <= '0;
        end else if (!stall) begin
            m_valid <= ex_valid && !flush;
            m_q     <= m_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_regWrite <= 1'b0;
            wb_data     <= '0;
            mem_err     <= 1'b0;
        end else begin
            wb_valid    <= wb_valid_nxt;
            wb_rd       <= m_q.rd;
            wb_regWrite <= m_q.reg_write && wb_valid_nxt;
            wb_data     <= m_q.mem_read ? dmem_rdata : m_q.alu_result;
            if (m_mis || timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    a_wait_holds_req: assert property (@(posedge clk) disable iff (rst) in_wait |-> dmem_req);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-instruction vector table, hand sequences, and a random stream
// checked against a queue-based model of retirement and memory-port activity.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, flush;
    logic [31:0] ex_ALUresult, ex_storeData;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack, stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, fd_mem_data, wb_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regWrite, wb_valid, wb_regWrite, mem_err;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ALUresult(ex_ALUresult), .ex_storeData(ex_storeData),
        .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .fd_mem_data(fd_mem_data), .mem_rd(mem_rd),
        .mem_regWrite(mem_regWrite), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .wb_data(wb_data), .mem_err(mem_err)
    );

    // Memory responder: acks once the request has been up for cur_lat cycles.
    int          cur_lat;
    logic [31:0] cur_rdata;
    logic [4:0]  rsp_age;
    assign dmem_ack   = dmem_req && (int'(rsp_age) == cur_lat);
    assign dmem_rdata = cur_rdata;
    always @(posedge clk or posedge rst) begin
        if (rst) rsp_age <= 5'd0;
        else if (dmem_req && !dmem_ack && rsp_age < 5'd15) rsp_age <= rsp_age + 5'd1;
        else rsp_age <= 5'd0;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic fl, input logic mr, input logic mw,
                            input logic rw, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] sd);
        ex_valid = v; flush = fl; ex_memRead = mr; ex_memWrite = mw;
        ex_regWrite = rw; ex_rd = rd; ex_ALUresult = alu; ex_storeData = sd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        cur_lat = 99; cur_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        v, fl, mr, mw, rw;
        logic [4:0]  rd;
        logic [31:0] alu, sd;
        int          lat;
        logic [31:0] rdata;
        logic        e_wbv, e_rw;
        logic [31:0] e_data;
        int          e_stalls;
        logic        e_req, e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t t);
        int stalls;
        do_reset();
        drive_ex(t.v, t.fl, t.mr, t.mw, t.rw, t.rd, t.alu, t.sd);
        cur_lat = t.lat; cur_rdata = t.rdata;
        @(posedge clk); #1;
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        stalls = 0;
        @(negedge clk);
        while (stall === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        chk({t.name, ".stall_cycles"}, stalls, t.e_stalls);
        chk({t.name, ".req_at_retire"}, 32'(dmem_req), 32'(t.e_req));
        if (t.e_req) begin
            chk({t.name, ".addr"}, dmem_addr, t.alu);
            chk({t.name, ".we"}, 32'(dmem_we), 32'(t.mw));
            if (t.mw) chk({t.name, ".wdata"}, dmem_wdata, t.sd);
        end
        @(negedge clk);
        chk({t.name, ".wb_valid"}, 32'(wb_valid), 32'(t.e_wbv));
        chk({t.name, ".wb_regWrite"}, 32'(wb_regWrite), 32'(t.e_rw));
        chk({t.name, ".mem_err"}, 32'(mem_err), 32'(t.e_err));
        if (t.e_wbv) begin
            chk({t.name, ".wb_data"}, wb_data, t.e_data);
            chk({t.name, ".wb_rd"}, 32'(wb_rd), 32'(t.rd));
        end
    endtask

    // Random-stream model: ops in M waiting on memory, and the expected retirement stream.
    typedef struct { logic [31:0] addr, wdata, rdata; logic we; int lat; } mop_t;
    typedef struct { logic [4:0] rd; logic rw; logic [31:0] data; } ret_t;
    mop_t        mq[$];
    ret_t        rq[$];
    int          m_age;
    logic        model_err;
    int          ex_lat;
    logic [31:0] ex_rdata;

    task automatic gen_ex();
        int          k, r;
        logic [31:0] a;
        k = $urandom_range(0, 3);
        a = $urandom;
        if (k >= 2) a[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        drive_ex($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, k == 2, k == 3,
                 1'($urandom), 5'($urandom), a, $urandom);
        r = $urandom_range(0, 19);
        ex_lat   = (r <= 14) ? $urandom_range(0, 3) : (r <= 17) ? $urandom_range(4, 15) : 16;
        ex_rdata = $urandom;
    endtask

    task automatic rand_cycle(output bit acc);
        logic req_e, ack_e, tmo_e, stall_e, live, is_mem, mis;
        ret_t r;
        @(negedge clk);
        if (wb_valid) begin
            if (rq.size() == 0) begin
                tests++; fails++;
                $display("FAIL rand.unexpected_retire: actual wb_valid=1 required no retirement");
            end else begin
                r = rq.pop_front();
                chk("rand.wb_data", wb_data, r.data);
                chk("rand.wb_rd", 32'(wb_rd), 32'(r.rd));
                chk("rand.wb_regWrite", 32'(wb_regWrite), 32'(r.rw));
            end
        end else begin
            chk("rand.bubble_regWrite", 32'(wb_regWrite), 32'd0);
        end
        req_e = (mq.size() != 0);
        ack_e = 1'b0;
        tmo_e = 1'b0;
        if (req_e) begin
            ack_e = (m_age == mq[0].lat);
            tmo_e = !ack_e && (m_age == 15);
        end
        stall_e = req_e && !ack_e && !tmo_e;
        chk("rand.dmem_req", 32'(dmem_req), 32'(req_e));
        chk("rand.stall", 32'(stall), 32'(stall_e));
        if (req_e) begin
            chk("rand.dmem_addr", dmem_addr, mq[0].addr);
            chk("rand.dmem_we", 32'(dmem_we), 32'(mq[0].we));
            if (mq[0].we) chk("rand.dmem_wdata", dmem_wdata, mq[0].wdata);
        end
        if (ack_e || tmo_e) begin
            void'(mq.pop_front());
            m_age = 0;
        end else if (req_e) begin
            m_age++;
        end
        acc = !stall;
        if (acc) begin
            live   = ex_valid && !flush;
            is_mem = ex_memRead || ex_memWrite;
            mis    = ex_ALUresult[1:0] != 2'b00;
            if (live && is_mem && !mis)
                mq.push_back('{ex_ALUresult, ex_storeData, ex_rdata, ex_memWrite, ex_lat});
            if (live && is_mem && (mis || ex_lat > 15)) model_err = 1'b1;
            if (live && (!is_mem || (!mis && ex_lat <= 15)))
                rq.push_back('{ex_rd, ex_regWrite, ex_memRead ? ex_rdata : ex_ALUresult});
        end
        @(posedge clk); #1;
        if (mq.size() != 0) begin
            cur_lat = mq[0].lat; cur_rdata = mq[0].rdata;
        end else begin
            cur_lat = 99;
        end
    endtask

    initial begin
        bit acc;
        int nacc;
        vecs[0] = '{"alu",        1,0,0,0,1, 5'd5, 32'h1234, 32'h0,        0,  32'h0,        1,1, 32'h1234,     0,  0,0};
        vecs[1] = '{"load_lat3",  1,0,1,0,1, 5'd7, 32'h100,  32'h0,        3,  32'hCAFEF00D, 1,1, 32'hCAFEF00D, 3,  1,0};
        vecs[2] = '{"store_ack0", 1,0,0,1,0, 5'd0, 32'h40,   32'hA5A5A5A5, 0,  32'h0,        1,0, 32'h40,       0,  1,0};
        vecs[3] = '{"load_mis",   1,0,1,0,1, 5'd3, 32'h102,  32'h0,        0,  32'hDEAD,     0,0, 32'h0,        0,  0,1};
        vecs[4] = '{"load_tmo",   1,0,1,0,1, 5'd4, 32'h200,  32'h0,        99, 32'h0,        0,0, 32'h0,        15, 1,1};
        vecs[5] = '{"flush_alu",  1,1,0,0,1, 5'd6, 32'h55,   32'h0,        0,  32'h0,        0,0, 32'h0,        0,  0,0};
        vecs[6] = '{"load_lat15", 1,0,1,0,1, 5'd8, 32'h300,  32'h0,        15, 32'h11112222, 1,1, 32'h11112222, 15, 1,0};
        vecs[7] = '{"store_mis",  1,0,0,1,0, 5'd0, 32'h41,   32'h77,       0,  32'h0,        0,0, 32'h0,        0,  0,1};
        vecs[8] = '{"load_flush", 1,1,1,0,1, 5'd9, 32'h104,  32'h0,        0,  32'h9,        0,0, 32'h0,        0,  0,0};
        vecs[9] = '{"invalid",    0,0,1,0,1, 5'd2, 32'h108,  32'h0,        0,  32'h0,        0,0, 32'h0,        0,  0,0};

        do_reset();
        @(negedge clk);
        chk("reset.dmem_req", 32'(dmem_req), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.wb_valid", 32'(wb_valid), 32'd0);
        chk("reset.wb_data", wb_data, 32'd0);
        chk("reset.mem_err", 32'(mem_err), 32'd0);
        chk("reset.mem_regWrite", 32'(mem_regWrite), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back loads: second request follows the first ack with no gap.
        do_reset();
        drive_ex(1, 0, 1, 0, 1, 5'd1, 32'h10, 32'h0);
        cur_lat = 1; cur_rdata = 32'hAAAA0001;
        @(posedge clk); #1;
        drive_ex(1, 0, 1, 0, 1, 5'd2, 32'h20, 32'h0);
        @(negedge clk);
        chk("b2b.stall_first", 32'(stall), 32'd1);
        chk("b2b.fd_mem_data", fd_mem_data, 32'h10);
        chk("b2b.mem_rd", 32'(mem_rd), 32'd1);
        chk("b2b.mem_regWrite", 32'(mem_regWrite), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.ack_no_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        cur_rdata = 32'hBBBB0002;
        drive_ex(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b.req_second", 32'(dmem_req), 32'd1);
        chk("b2b.addr_second", dmem_addr, 32'h20);
        chk("b2b.wb_first", wb_data, 32'hAAAA0001);
        chk("b2b.wb_rd_first", 32'(wb_rd), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.wb_second", wb_data, 32'hBBBB0002);
        chk("b2b.wb_rd_second", 32'(wb_rd), 32'd2);
        chk("b2b.req_idle", 32'(dmem_req), 32'd0);

        // Asynchronous reset while waiting on memory.
        do_reset();
        drive_ex(1, 0, 1, 0, 1, 5'd4, 32'h80, 32'h0);
        cur_lat = 99;
        @(posedge clk); #1;
        drive_ex(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("arst.pre_stall", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst.dmem_req", 32'(dmem_req), 32'd0);
        chk("arst.stall", 32'(stall), 32'd0);
        chk("arst.wb_valid", 32'(wb_valid), 32'd0);
        chk("arst.fd_mem_data", fd_mem_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        drive_ex(1, 0, 0, 0, 1, 5'd3, 32'h77, 32'h0);
        @(posedge clk); #1;
        drive_ex(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst.after_wb_valid", 32'(wb_valid), 32'd1);
        chk("arst.after_wb_data", wb_data, 32'h77);

        // Random stream against the model.
        do_reset();
        mq.delete(); rq.delete(); m_age = 0; model_err = 1'b0;
        gen_ex();
        nacc = 0;
        for (int cyc = 0; cyc < 8000 && nacc < 300; cyc++) begin
            rand_cycle(acc);
            if (acc) begin
                nacc++;
                gen_ex();
            end else begin
                flush = $urandom_range(0, 3) == 0;
            end
        end
        chk("rand.accepted", nacc, 300);
        drive_ex(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) rand_cycle(acc);
        chk("rand.retire_drained", rq.size(), 0);
        chk("rand.mem_drained", mq.size(), 0);
        chk("rand.mem_err", 32'(mem_err), 32'(model_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
